// File: rtl/network_injector_arbiter.sv
// Round-robin, packet-atomic (per virtual network) arbiter feeding a tile's NoC injection port.
// One flit is granted per cycle and presented on a registered output stage.
module network_injector_arbiter #(
  parameter int NumRequesters                    = 2,
  parameter int NetworkIfFlitWidth               = 64,
  parameter int NetworkIfFlitTypeWidth           = 2,
  parameter int NetworkIfBroadcastWidth          = 1,
  parameter int NetworkIfVirtualNetworkIdWidth   = 1,
  parameter int NetworkIfNumberOfVirtualNetworks = 2,
  localparam int DataWidth = NetworkIfFlitWidth + NetworkIfFlitTypeWidth +
                             NetworkIfBroadcastWidth + NetworkIfVirtualNetworkIdWidth
) (
  input  logic                                            clk_i,
  input  logic                                            rst_ni,
  input  logic [NumRequesters-1:0]                        valid_i,
  output logic [NumRequesters-1:0]                        ready_o,
  input  logic [NumRequesters*DataWidth-1:0]              data_i,
  output logic                                            network_valid_o,
  input  logic [NetworkIfNumberOfVirtualNetworks-1:0]     network_ready_i,
  output logic [NetworkIfFlitWidth-1:0]                   network_flit_o,
  output logic [NetworkIfFlitTypeWidth-1:0]               network_flit_type_o,
  output logic [NetworkIfBroadcastWidth-1:0]              network_broadcast_o,
  output logic [NetworkIfVirtualNetworkIdWidth-1:0]       network_virtual_network_id_o,
  output logic                                            protocol_error_o
);

  localparam int FW = NetworkIfFlitWidth;
  localparam int TW = NetworkIfFlitTypeWidth;
  localparam int BW = NetworkIfBroadcastWidth;
  localparam int VW = NetworkIfVirtualNetworkIdWidth;
  localparam int V  = NetworkIfNumberOfVirtualNetworks;
  localparam int R  = NumRequesters;
  localparam int RW = (R > 1) ? $clog2(R) : 1;

  localparam logic [TW-1:0] TypeHeader     = TW'(32'd0);
  localparam logic [TW-1:0] TypePayload    = TW'(32'd1);
  localparam logic [TW-1:0] TypeTail       = TW'(32'd2);
  localparam logic [TW-1:0] TypeHeaderTail = TW'(32'd3);

  logic [R-1:0][FW-1:0] req_flit_s;
  logic [R-1:0][TW-1:0] req_type_s;
  logic [R-1:0][BW-1:0] req_bcast_s;
  logic [R-1:0][VW-1:0] req_vn_s;
  logic [R-1:0]         head_s;
  logic [R-1:0]         own_s;
  logic [R-1:0]         elig_s;
  logic [R-1:0]         viol_s;

  logic                 grant_s;
  logic [RW-1:0]        winner_s;
  logic [RW:0]          scan_s;
  logic [VW-1:0]        win_vn_s;
  logic [TW-1:0]        win_type_s;

  logic [V-1:0]         lock_valid_q, lock_valid_d;
  logic [V-1:0][RW-1:0] lock_owner_q, lock_owner_d;
  logic [RW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 net_valid_q, net_valid_d;
  logic [FW-1:0]        net_flit_q, net_flit_d;
  logic [TW-1:0]        net_type_q, net_type_d;
  logic [BW-1:0]        net_bcast_q, net_bcast_d;
  logic [VW-1:0]        net_vn_q, net_vn_d;
  logic                 err_q, err_d;

  // Unpack each requester and decide eligibility and protocol violations.
  always_comb begin
    elig_s = '0;
    viol_s = '0;
    head_s = '0;
    own_s  = '0;
    for (int r = 0; r < R; r++) begin
      req_flit_s[r]  = data_i[r*DataWidth +: FW];
      req_type_s[r]  = data_i[r*DataWidth + FW +: TW];
      req_bcast_s[r] = data_i[r*DataWidth + FW + TW +: BW];
      req_vn_s[r]    = data_i[r*DataWidth + FW + TW + BW +: VW];
      head_s[r]      = (req_type_s[r] == TypeHeader) || (req_type_s[r] == TypeHeaderTail);
      // A VN id outside the configured range can never be granted.
      if (int'(req_vn_s[r]) < V) begin
        own_s[r]  = lock_valid_q[req_vn_s[r]] && (lock_owner_q[req_vn_s[r]] == RW'(r));
        elig_s[r] = valid_i[r] && network_ready_i[req_vn_s[r]] &&
                    ((!lock_valid_q[req_vn_s[r]] && head_s[r]) || own_s[r]);
        viol_s[r] = valid_i[r] && !head_s[r] && !own_s[r];
      end else begin
        own_s[r]  = 1'b0;
        elig_s[r] = 1'b0;
        viol_s[r] = 1'b0;
      end
    end
  end

  // Round-robin scan starting at the pointer.
  always_comb begin
    grant_s  = 1'b0;
    winner_s = '0;
    scan_s   = '0;
    for (int i = 0; i < R; i++) begin
      scan_s = {1'b0, rr_ptr_q} + (RW+1)'(i);
      if (scan_s >= (RW+1)'(R)) begin
        scan_s = scan_s - (RW+1)'(R);
      end else begin
        scan_s = scan_s;
      end
      if (!grant_s && elig_s[scan_s[RW-1:0]]) begin
        grant_s  = 1'b1;
        winner_s = scan_s[RW-1:0];
      end else begin
        grant_s  = grant_s;
      end
    end
  end

  // One-hot accept towards the winning requester.
  always_comb begin
    ready_o = '0;
    if (rst_ni && grant_s) begin
      ready_o[winner_s] = 1'b1;
    end else begin
      ready_o = '0;
    end
  end

  assign win_vn_s   = req_vn_s[winner_s];
  assign win_type_s = req_type_s[winner_s];

  // Next-state: output stage, per-VN locks, pointer and sticky error.
  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    rr_ptr_d     = rr_ptr_q;
    net_valid_d  = grant_s;
    net_flit_d   = net_flit_q;
    net_type_d   = net_type_q;
    net_bcast_d  = net_bcast_q;
    net_vn_d     = net_vn_q;
    err_d        = err_q | (|viol_s);
    if (grant_s) begin
      net_flit_d  = req_flit_s[winner_s];
      net_type_d  = win_type_s;
      net_bcast_d = req_bcast_s[winner_s];
      net_vn_d    = win_vn_s;
      rr_ptr_d    = (winner_s == RW'(R-1)) ? '0 : winner_s + RW'(1);
      case (win_type_s)
        TypeHeader: begin
          // A header from the current owner restarts nothing but is illegal.
          if (own_s[winner_s]) begin
            err_d = 1'b1;
          end else begin
            err_d = err_d;
          end
          lock_valid_d[win_vn_s] = 1'b1;
          lock_owner_d[win_vn_s] = winner_s;
        end
        TypeTail:       lock_valid_d[win_vn_s] = 1'b0;
        TypePayload:    lock_valid_d = lock_valid_q;
        TypeHeaderTail: lock_valid_d = lock_valid_q;
        default:        lock_valid_d = lock_valid_q;
      endcase
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lock_valid_q <= '0;
      lock_owner_q <= '0;
      rr_ptr_q     <= '0;
      net_valid_q  <= 1'b0;
      net_flit_q   <= '0;
      net_type_q   <= '0;
      net_bcast_q  <= '0;
      net_vn_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      lock_valid_q <= lock_valid_d;
      lock_owner_q <= lock_owner_d;
      rr_ptr_q     <= rr_ptr_d;
      net_valid_q  <= net_valid_d;
      net_flit_q   <= net_flit_d;
      net_type_q   <= net_type_d;
      net_bcast_q  <= net_bcast_d;
      net_vn_q     <= net_vn_d;
      err_q        <= err_d;
    end
  end

  assign network_valid_o              = net_valid_q;
  assign network_flit_o               = net_flit_q;
  assign network_flit_type_o          = net_type_q;
  assign network_broadcast_o          = net_bcast_q;
  assign network_virtual_network_id_o = net_vn_q;
  assign protocol_error_o             = err_q;

endmodule

// File: tb/tb_network_injector_arbiter.sv
// Bench for network_injector_arbiter: directed scenarios plus randomized traffic,
// all checked against a lock-table / round-robin reference model.
module tb_network_injector_arbiter;
  localparam int R  = 2;
  localparam int V  = 2;
  localparam int FW = 64;
  localparam int DW = 68;
  localparam logic [1:0] HD = 2'd0;
  localparam logic [1:0] PL = 2'd1;
  localparam logic [1:0] TL = 2'd2;
  localparam logic [1:0] HT = 2'd3;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [R-1:0]    valid_i = '0;
  logic [R-1:0]    ready_o;
  logic [R*DW-1:0] data_i = '0;
  logic            network_valid_o;
  logic [V-1:0]    network_ready_i = '0;
  logic [FW-1:0]   network_flit_o;
  logic [1:0]      network_flit_type_o;
  logic [0:0]      network_broadcast_o;
  logic [0:0]      network_virtual_network_id_o;
  logic            protocol_error_o;

  network_injector_arbiter dut (
    .clk_i                        (clk_i),
    .rst_ni                       (rst_ni),
    .valid_i                      (valid_i),
    .ready_o                      (ready_o),
    .data_i                       (data_i),
    .network_valid_o              (network_valid_o),
    .network_ready_i              (network_ready_i),
    .network_flit_o               (network_flit_o),
    .network_flit_type_o          (network_flit_type_o),
    .network_broadcast_o          (network_broadcast_o),
    .network_virtual_network_id_o (network_virtual_network_id_o),
    .protocol_error_o             (protocol_error_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: lock owner per VN (-1 = free), next round-robin start, sticky error.
  int          m_owner [V];
  int          m_rr;
  bit          m_err;
  int          m_win;
  logic [R-1:0] exp_ready, obs_ready;
  logic        exp_nv, obs_nv, obs_err;
  logic [DW-1:0] exp_fl, obs_fl;

  function automatic logic [DW-1:0] pk(input logic vn, input logic bc, input logic [1:0] t,
                                       input logic [FW-1:0] f);
    return {vn, bc, t, f};
  endfunction

  function automatic logic [1:0] ptype(input int k, input int len);
    if (k == 0) return HD;
    if (k == len - 1) return TL;
    return PL;
  endfunction

  function automatic logic [FW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic model_reset();
    for (int v = 0; v < V; v++) m_owner[v] = -1;
    m_rr  = 0;
    m_err = 1'b0;
  endtask

  // Drive one cycle, predict it with the model, and capture DUT observations.
  task automatic cycle(input logic [R-1:0] v, input logic [R*DW-1:0] d, input logic [V-1:0] nr);
    logic [DW-1:0] f;
    int fvn, ft, r;
    valid_i = v;
    data_i = d;
    network_ready_i = nr;
    #4;
    obs_ready = ready_o;
    m_win = -1;
    if (rst_ni) begin
      for (int k = 0; k < R; k++) begin
        r = (m_rr + k) % R;
        f = d[r*DW +: DW];
        fvn = int'(f[DW-1]);
        ft = int'(f[FW+1:FW]);
        if (m_win < 0 && v[r] && nr[fvn] &&
            ((m_owner[fvn] < 0 && (ft == 0 || ft == 3)) || m_owner[fvn] == r)) m_win = r;
      end
      for (int k = 0; k < R; k++) begin
        f = d[k*DW +: DW];
        fvn = int'(f[DW-1]);
        ft = int'(f[FW+1:FW]);
        if (v[k] && (ft == 1 || ft == 2) && m_owner[fvn] != k) m_err = 1'b1;
      end
    end
    exp_ready = '0;
    if (m_win >= 0) exp_ready[m_win] = 1'b1;
    @(posedge clk_i);
    #1;
    obs_nv  = network_valid_o;
    obs_fl  = {network_virtual_network_id_o, network_broadcast_o, network_flit_type_o, network_flit_o};
    obs_err = protocol_error_o;
    if (!rst_ni) begin
      model_reset();
      exp_nv = 1'b0;
      exp_fl = '0;
    end else if (m_win >= 0) begin
      f = d[m_win*DW +: DW];
      fvn = int'(f[DW-1]);
      ft = int'(f[FW+1:FW]);
      exp_nv = 1'b1;
      exp_fl = f;
      m_rr = (m_win + 1) % R;
      if (ft == 0) begin
        if (m_owner[fvn] == m_win) m_err = 1'b1;
        m_owner[fvn] = m_win;
      end else if (ft == 2) begin
        m_owner[fvn] = -1;
      end
    end else begin
      exp_nv = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(2'b11, {pk(0, 0, HD, 64'h11), pk(0, 0, HD, 64'h10)}, 2'b11);
      checks++;
      if (obs_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", obs_ready); end
      checks++;
      if (obs_nv !== 1'b0 || obs_err !== 1'b0 || obs_fl !== '0) begin
        errors++; $display("FAIL reset_outputs: valid=%b err=%b fields=%h want all 0", obs_nv, obs_err, obs_fl);
      end
    end
    rst_ni = 1'b1;
    cycle(2'b11, {pk(0, 1, HT, 64'hB1), pk(0, 0, HT, 64'hA0)}, 2'b11);
    checks++;
    if (obs_ready !== 2'b01 || obs_fl !== pk(0, 0, HT, 64'hA0) || obs_nv !== 1'b1) begin
      errors++; $display("FAIL reset_first_grant: ready=%b flit=%h want ready=01 flit=%h", obs_ready, obs_fl, pk(0, 0, HT, 64'hA0));
    end
    cycle(2'b11, {pk(0, 1, HT, 64'hB1), pk(0, 0, HT, 64'hA0)}, 2'b11);
    checks++;
    if (obs_ready !== 2'b10 || obs_fl !== pk(0, 1, HT, 64'hB1)) begin
      errors++; $display("FAIL reset_second_grant: ready=%b flit=%h want ready=10 flit=%h", obs_ready, obs_fl, pk(0, 1, HT, 64'hB1));
    end
    cycle(2'b00, '0, 2'b11);
    checks++;
    if (obs_nv !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b want 0", obs_nv); end
  endtask

  task automatic test_single_packet();
    logic [FW-1:0] f [3];
    for (int i = 0; i < 3; i++) f[i] = rnd64();
    for (int i = 0; i < 3; i++) begin
      cycle(2'b01, {{DW{1'b0}}, pk(0, 0, ptype(i, 3), f[i])}, 2'b11);
      checks++;
      if (obs_ready !== 2'b01) begin errors++; $display("FAIL single_ready[%0d]: got %b want 01", i, obs_ready); end
      checks++;
      if (obs_nv !== 1'b1 || obs_fl !== pk(0, 0, ptype(i, 3), f[i])) begin
        errors++; $display("FAIL single_flit[%0d]: valid=%b got %h want %h", i, obs_nv, obs_fl, pk(0, 0, ptype(i, 3), f[i]));
      end
    end
    cycle(2'b00, '0, 2'b11);
    checks++;
    if (obs_nv !== 1'b0) begin errors++; $display("FAIL single_after: valid got %b want 0", obs_nv); end
  endtask

  task automatic test_atomicity();
    int n [R];
    int order [$];
    int gcyc [$];
    int want [6] = '{0, 0, 0, 1, 1, 1};
    logic [R-1:0] v;
    logic [R*DW-1:0] d;
    rst_ni = 1'b0;
    cycle(2'b00, '0, 2'b11);
    rst_ni = 1'b1;
    n[0] = 0;
    n[1] = 0;
    for (int c = 0; c < 12 && (n[0] < 3 || n[1] < 3); c++) begin
      for (int r = 0; r < R; r++) begin
        v[r] = (n[r] < 3);
        d[r*DW +: DW] = pk(0, 0, ptype(n[r] % 3, 3), FW'(64'h100 * (r + 1) + n[r]));
      end
      cycle(v, d, 2'b11);
      checks++;
      if (obs_ready !== exp_ready || obs_nv !== exp_nv || (exp_nv && obs_fl !== exp_fl)) begin
        errors++; $display("FAIL atomic_cycle%0d: ready=%b valid=%b flit=%h want ready=%b valid=%b flit=%h", c, obs_ready, obs_nv, obs_fl, exp_ready, exp_nv, exp_fl);
      end
      for (int r = 0; r < R; r++) if (obs_ready[r]) begin order.push_back(r); gcyc.push_back(c); end
      for (int r = 0; r < R; r++) if (exp_ready[r]) n[r]++;
    end
    checks++;
    if (order.size() != 6) begin
      errors++; $display("FAIL atomic_count: got %0d grants want 6", order.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (order[k] != want[k]) begin errors++; $display("FAIL atomic_order[%0d]: got %0d want %0d", k, order[k], want[k]); end
      end
      checks++;
      if (gcyc[3] != gcyc[2] + 1) begin errors++; $display("FAIL atomic_handover: header cycle %0d want %0d", gcyc[3], gcyc[2] + 1); end
    end
  endtask

  task automatic test_vn_interleave();
    int n [R];
    int order [$];
    logic [R-1:0] v;
    logic [R*DW-1:0] d;
    n[0] = 0;
    n[1] = 0;
    for (int c = 0; c < 12 && (n[0] < 4 || n[1] < 4); c++) begin
      for (int r = 0; r < R; r++) begin
        v[r] = (n[r] < 4);
        d[r*DW +: DW] = pk(r[0], 0, ptype(n[r] % 4, 4), rnd64());
      end
      cycle(v, d, 2'b11);
      checks++;
      if (obs_ready !== exp_ready || obs_nv !== exp_nv || (exp_nv && obs_fl !== exp_fl)) begin
        errors++; $display("FAIL vn_cycle%0d: ready=%b flit=%h want ready=%b flit=%h", c, obs_ready, obs_fl, exp_ready, exp_fl);
      end
      if (obs_nv) begin
        checks++;
        if (int'(obs_fl[DW-1]) != order.size() % 2) begin
          errors++; $display("FAIL vn_alternate[%0d]: vn got %0d want %0d", order.size(), obs_fl[DW-1], order.size() % 2);
        end
      end
      for (int r = 0; r < R; r++) if (obs_ready[r]) order.push_back(r);
      for (int r = 0; r < R; r++) if (exp_ready[r]) n[r]++;
    end
    checks++;
    if (order.size() != 8) begin errors++; $display("FAIL vn_count: got %0d grants want 8", order.size()); end
    for (int k = 0; k < order.size(); k++) begin
      checks++;
      if (order[k] != k % 2) begin errors++; $display("FAIL vn_fair[%0d]: got %0d want %0d", k, order[k], k % 2); end
    end
  endtask

  task automatic test_backpressure();
    int n0;
    int vn1_cnt;
    bit r1_done;
    logic [V-1:0] nr;
    logic [R-1:0] v;
    logic [R*DW-1:0] d;
    n0 = 0;
    vn1_cnt = 0;
    r1_done = 1'b0;
    for (int c = 0; c < 14 && (n0 < 4 || !r1_done); c++) begin
      nr = 2'b11;
      if (c >= 1 && c <= 5) nr[0] = 1'b0;
      v[0] = (n0 < 4);
      v[1] = (c >= 2) && !r1_done;
      d = {pk(1, 1, HT, 64'hFEED), pk(0, 0, ptype(n0 % 4, 4), FW'(64'hA000 + n0))};
      cycle(v, d, nr);
      checks++;
      if (obs_ready !== exp_ready || obs_nv !== exp_nv || (exp_nv && obs_fl !== exp_fl)) begin
        errors++; $display("FAIL bp_cycle%0d: ready=%b flit=%h want ready=%b flit=%h", c, obs_ready, obs_fl, exp_ready, exp_fl);
      end
      if (c >= 1 && c <= 5) begin
        checks++;
        if (obs_nv === 1'b1 && obs_fl[DW-1] === 1'b0) begin
          errors++; $display("FAIL bp_stall%0d: VN0 flit %h emitted while avail low", c, obs_fl);
        end
      end
      if (obs_nv === 1'b1 && obs_fl[DW-1] === 1'b1) vn1_cnt++;
      if (exp_ready[0]) n0++;
      if (exp_ready[1]) r1_done = 1'b1;
    end
    checks++;
    if (n0 != 4 || vn1_cnt != 1) begin
      errors++; $display("FAIL bp_done: vn0 flits %0d vn1 flits %0d want 4 and 1", n0, vn1_cnt);
    end
  endtask

  task automatic test_protocol_error();
    rst_ni = 1'b0;
    cycle(2'b00, '0, 2'b11);
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(2'b10, {pk(1, 0, PL, 64'hBAD), {DW{1'b0}}}, 2'b11);
      checks++;
      if (obs_ready !== 2'b00) begin errors++; $display("FAIL perr_ready%0d: got %b want 00", i, obs_ready); end
      checks++;
      if (obs_err !== 1'b1) begin errors++; $display("FAIL perr_flag%0d: got %b want 1", i, obs_err); end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(2'b00, '0, 2'b11);
      checks++;
      if (obs_err !== 1'b1) begin errors++; $display("FAIL perr_sticky%0d: got %b want 1", i, obs_err); end
    end
    rst_ni = 1'b0;
    cycle(2'b00, '0, 2'b11);
    rst_ni = 1'b1;
    checks++;
    if (obs_err !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b want 0", obs_err); end
  endtask

  task automatic test_random();
    bit in_pkt [R];
    logic pvn [R];
    logic [DW-1:0] cur [R];
    logic [R-1:0] cv;
    logic [V-1:0] nr;
    logic [R*DW-1:0] d;
    logic vn;
    logic [1:0] t;
    int bad;
    cv = '0;
    for (int r = 0; r < R; r++) begin in_pkt[r] = 1'b0; pvn[r] = 1'b0; cur[r] = '0; end
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      rst_ni = !(c == 200 || c == 201);
      for (int r = 0; r < R; r++) begin
        if (!cv[r] && $urandom_range(3) != 0) begin
          cv[r] = 1'b1;
          if (in_pkt[r]) begin
            vn = pvn[r];
            t = ($urandom_range(15) == 0) ? HD : (($urandom_range(1) == 0) ? PL : TL);
          end else begin
            vn = $urandom_range(1) != 0;
            t = ($urandom_range(63) == 0) ? PL : (($urandom_range(1) == 0) ? HD : HT);
          end
          cur[r] = pk(vn, $urandom_range(1) != 0, t, rnd64());
        end
        d[r*DW +: DW] = cur[r];
      end
      for (int v = 0; v < V; v++) nr[v] = ($urandom_range(3) != 0);
      cycle(cv, d, nr);
      checks++;
      if (obs_ready !== exp_ready) begin
        bad++; errors++; $display("FAIL rand_ready c%0d: got %b want %b", c, obs_ready, exp_ready);
      end
      checks++;
      if (obs_nv !== exp_nv || (exp_nv && obs_fl !== exp_fl)) begin
        bad++; errors++; $display("FAIL rand_out c%0d: valid=%b flit=%h want valid=%b flit=%h", c, obs_nv, obs_fl, exp_nv, exp_fl);
      end
      checks++;
      if (obs_err !== m_err) begin
        bad++; errors++; $display("FAIL rand_err c%0d: got %b want %b", c, obs_err, m_err);
      end
      for (int r = 0; r < R; r++) begin
        if (exp_ready[r]) begin
          if (cur[r][FW+1:FW] == HD) begin in_pkt[r] = 1'b1; pvn[r] = cur[r][DW-1]; end
          else if (cur[r][FW+1:FW] == TL) in_pkt[r] = 1'b0;
          cv[r] = 1'b0;
        end else if ($urandom_range(7) == 0) begin
          cv[r] = 1'b0;
        end
        if (!rst_ni) begin in_pkt[r] = 1'b0; cv[r] = 1'b0; end
      end
      if (bad > 20) break;
    end
    rst_ni = 1'b1;
  endtask

  initial begin
    model_reset();
    exp_nv = 1'b0;
    exp_fl = '0;
    test_reset();
    test_single_packet();
    test_atomicity();
    test_vn_interleave();
    test_backpressure();
    test_protocol_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/network_injector_arbiter.md
# network_injector_arbiter

Shares the single network injection port of a tile among several local traffic sources. Arbitration is round-robin, packet-atomic per virtual network (VN). Each requester presents packed flits ({vn_id, broadcast, flit_type, flit}, same packing as the ejection side). The block grants one flit per cycle to an eligible requester and drives the NoC valid/avail handshake through a registered output stage. Flits of different VNs may interleave on the link; flits of different packets on the same VN never interleave.

## Interface
- NumRequesters, 2: number of local sources R (≥2); pointer width RW = max(1, clog2(R)).
- NetworkIfFlitWidth, 64: flit width.
- NetworkIfFlitTypeWidth, 2: flit type width; encoding header=0, payload=1, tail=2, header_tail=3.
- NetworkIfBroadcastWidth, 1: broadcast field width.
- NetworkIfVirtualNetworkIdWidth, 1: VN id width.
- NetworkIfNumberOfVirtualNetworks, 2: number of VNs V.
- DataWidth (localparam): sum of the four field widths above.
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous reset, active-low.
- valid_i  in  R  per-requester flit valid.
- ready_o  out  R  per-requester accept; combinational, one-hot or zero.
- data_i  in  R*DataWidth  requester r in bits [r*DataWidth +: DataWidth], packed {vn_id, broadcast, flit_type, flit}.
- network_valid_o  out  1  registered flit valid.
- network_ready_i  in  V  per-VN avail; may be high without valid.
- network_flit_o / network_flit_type_o / network_broadcast_o / network_virtual_network_id_o  out  field widths  registered flit fields.
- protocol_error_o  out  1  sticky protocol violation flag.

## Operation
- Per-VN lock state: lock_valid[v], lock_owner[v] (RW bits). Round-robin pointer rr_ptr (RW bits).
- Requester r, with VN v = data_i vn field and type t, is eligible when all of the following hold:
  - valid_i[r]=1 and network_ready_i[v]=1;
  - either lock_valid[v]=0 and t∈{header, header_tail}, or lock_valid[v]=1 and lock_owner[v]=r.
- Winner selection:
  - First eligible requester scanning rr_ptr, rr_ptr+1, … mod R.
  - ready_o[winner]=1; all other ready_o bits 0. No eligible requester → ready_o=0.
- On a grant to winner w with VN v and type t:
  - Output register loads the flit; rr_ptr <= (w+1) mod R.
  - t=header: lock_valid[v]<=1, lock_owner[v]<=w.
  - t=tail: lock_valid[v]<=0.
  - header_tail or payload: lock unchanged.
- Blocking cases:
  - Requester with payload/tail and no lock it owns: not eligible; stalls; protocol_error_o<=1.
  - Header while another requester holds the lock: waits, no error.
- Owner presents header again: granted, lock kept, protocol_error_o<=1.
- Locks on distinct VNs are independent; a stalled VN never blocks another VN's requesters.
- Reset:
  - network_valid_o=0, all output fields 0.
  - lock_valid=0, rr_ptr=0, protocol_error_o=0.
  - ready_o=0 while rst_ni=0.
- Reset mid-packet drops all locks; the next flit accepted for that VN must be a header.

## Timing
- Latency: grant in cycle t → network_valid_o=1 with that flit in cycle t+1, for exactly one cycle.
- Without a grant in cycle t, network_valid_o=0 in t+1.
- network_ready_i[v] sampled in cycle t authorizes the single flit driven in t+1. The downstream avail already accounts for the flit in flight; no output back-pressure exists after the grant.
- Throughput: one flit per cycle, sustained across requesters and VNs.
- ready_o depends combinationally on valid_i, data_i, network_ready_i and state. The requester's transfer occurs when valid_i[r] & ready_o[r].
- Lock and pointer updates take effect in the cycle after the grant. A tail granted in cycle t frees the VN for a header in cycle t+1.
- protocol_error_o rises the cycle after the violation and stays high until reset.

## Test plan
- Reset: hold rst_ni=0 for 3 cycles with all valid_i=1 → ready_o=0, network_valid_o=0, protocol_error_o=0; first grant after release goes to requester 0.
- Single packet: R=2, requester 0 sends header/payload/tail on VN0 with network_ready_i=2'b11 → ready_o[0] high 3 consecutive cycles; flits appear on the network at t+1..t+3 in order with vn_id=0.
- Packet atomicity: requesters 0 and 1 both start 3-flit packets on VN0 in the same cycle → requester 0's three flits all precede requester 1's header; requester 1's header is granted the cycle after requester 0's tail.
- VN interleave and fairness: requester 0 on VN0, requester 1 on VN1, both streaming 4-flit packets → grants alternate 0,1,0,1…; network_virtual_network_id_o alternates 0,1.
- Back-pressure: network_ready_i[0]=0 for 5 cycles mid-packet on VN0 while requester 1 sends a header_tail on VN1 → VN0 stalls with no VN0 flits; the VN1 flit passes; VN0 resumes after ready returns.
- Protocol error: requester 1 presents a payload on idle VN1 → ready_o[1] stays 0; protocol_error_o=1 next cycle and stays 1 until reset.
